button_debouncer: RTL and testbench

- Input-side counterpart to the LED driver: reads a raw, bouncing pushbutton pin and turns it into a clean debounced level plus single-cycle event pulses.
- Sits between a top-level input pad and user logic, in the same PLL-derived clk domain as the blink logic.
- Functions: synchronise the pin, sample it on a slow divided tick, accept a level change only after it has been stable for N samples, detect long presses, count presses.

---
 rtl/button_debouncer.sv | 181 ++++++++++++++++++
 tb/tb_button_debouncer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Pushbutton conditioner. The raw pin is synchronised with two
//               flops and normalised so that 1 means "pressed". It is then
//               sampled on a slow divided tick. A level change is accepted only
//               after STABLE_SAMPLES consecutive differing samples. Press,
//               release and long-press events are emitted as single-cycle
//               pulses, and accepted presses are counted.
// Ports       : clk              - system clock
//               reset            - synchronous, active-high reset
//               btn_in           - raw asynchronous button pin
//               btn_level        - debounced state, 1 = pressed
//               press_pulse      - one cycle after a press is accepted
//               release_pulse    - one cycle after a release is accepted
//               long_press_pulse - one cycle when a hold reaches
//                                  LONG_PRESS_SAMPLES ticks
//               press_count      - accepted presses, wraps modulo 2^COUNT_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int SAMPLE_DIVIDER     = 24000,
    parameter int STABLE_SAMPLES     = 10,
    parameter int LONG_PRESS_SAMPLES = 1000,
    parameter int ACTIVE_LOW         = 1,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_in,
    output logic                   btn_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   long_press_pulse,
    output logic [COUNT_WIDTH-1:0] press_count
);

    localparam int TICK_W = (SAMPLE_DIVIDER > 2) ? $clog2(SAMPLE_DIVIDER) : 1;
    localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_SAMPLES + 1);

    // Pin value when the button is not pressed.
    localparam logic              c_IDLE_PIN  = (ACTIVE_LOW != 0);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(SAMPLE_DIVIDER - 1);
    localparam logic [STAB_W-1:0] c_STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_MAX  = HOLD_W'(LONG_PRESS_SAMPLES);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(LONG_PRESS_SAMPLES - 1);

    localparam logic [1:0] c_RELEASED     = 2'd0;
    localparam logic [1:0] c_PRESS_PEND   = 2'd1;
    localparam logic [1:0] c_PRESSED      = 2'd2;
    localparam logic [1:0] c_RELEASE_PEND = 2'd3;

    logic                   r_sync1;
    logic                   r_sync2;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [1:0]             r_state;
    logic [STAB_W-1:0]      r_stab_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_level;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   r_long_pulse;
    logic [COUNT_WIDTH-1:0] r_press_count;

    logic w_s;
    logic w_tick;
    logic w_stable;
    logic w_differ;
    logic w_accept;
    logic w_press_accept;
    logic w_release_accept;
    logic w_hold_step;
    logic w_long_fire;

    // Two-flop synchroniser; reset loads the idle pin level so that leaving
    // reset can never look like a press edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= c_IDLE_PIN;
            r_sync2 <= c_IDLE_PIN;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Polarity-normalised sample: 1 = pressed.
    assign w_s = r_sync2 ^ c_IDLE_PIN;

    // Free-running sample-tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick   = (r_tick_cnt == c_TICK_LAST);
    assign w_stable = (r_state == c_RELEASED) || (r_state == c_PRESSED);
    assign w_differ = (w_s != r_level);

    // Acceptance: from a stable state only when a single sample suffices,
    // otherwise from a pending state on the sample that completes the run.
    assign w_accept = w_tick && w_differ &&
                      (w_stable ? (STABLE_SAMPLES == 1) : (r_stab_cnt == c_STAB_LAST));
    assign w_press_accept   = w_accept && !r_level;
    assign w_release_accept = w_accept &&  r_level;

    // Hold counting saturates; the long pulse fires on the step that reaches
    // the limit, and a release accepted on that same tick takes precedence.
    assign w_hold_step = w_tick && r_level && (r_hold_cnt != c_HOLD_MAX);
    assign w_long_fire = w_hold_step && (r_hold_cnt == c_HOLD_LAST) && !w_release_accept;

    // Debounce state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_RELEASED;
            r_stab_cnt <= '0;
            r_level    <= 1'b0;
        end else if (w_tick) begin
            if (w_accept) begin
                r_level    <= ~r_level;
                r_state    <= r_level ? c_RELEASED : c_PRESSED;
                r_stab_cnt <= '0;
            end else begin
                case (r_state)
                    c_RELEASED, c_PRESSED: begin
                        if (w_differ) begin
                            r_state    <= (r_state == c_RELEASED) ? c_PRESS_PEND : c_RELEASE_PEND;
                            r_stab_cnt <= STAB_W'(1);
                        end else begin
                            r_stab_cnt <= '0;
                        end
                    end
                    default: begin
                        if (w_differ) begin
                            r_stab_cnt <= r_stab_cnt + STAB_W'(1);
                        end else begin
                            // Glitch: fall back to the stable state we came from.
                            r_state    <= r_level ? c_PRESSED : c_RELEASED;
                            r_stab_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // Hold counter, event pulses and press counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt      <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_press_pulse   <= w_press_accept;
            r_release_pulse <= w_release_accept;
            r_long_pulse    <= w_long_fire;
            if (w_press_accept) begin
                r_hold_cnt    <= '0;
                r_press_count <= r_press_count + COUNT_WIDTH'(1);
            end else if (w_hold_step) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign btn_level        = r_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign press_count      = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Directed self-checking bench for button_debouncer with
//               SAMPLE_DIVIDER=4, STABLE_SAMPLES=3, LONG_PRESS_SAMPLES=8,
//               ACTIVE_LOW=1, COUNT_WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [3:0] press_count;

    int n_cmp;
    int n_fail;

    // Running pulse totals, sampled shortly after each rising edge.
    int n_press;
    int n_release;
    int n_long;

    button_debouncer #(
        .SAMPLE_DIVIDER     (4),
        .STABLE_SAMPLES     (3),
        .LONG_PRESS_SAMPLES (8),
        .ACTIVE_LOW         (1),
        .COUNT_WIDTH        (4)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .btn_in           (btn_in),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .press_count      (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (press_pulse)      n_press++;
        if (release_pulse)    n_release++;
        if (long_press_pulse) n_long++;
    end

    task automatic do_reset(input logic pin);
        @(negedge clk);
        btn_in = pin;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        int p0, r0, l0;
        @(negedge clk);
        btn_in = 1'b1;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (btn_level !== 1'b0 || press_count !== 4'd0 || press_pulse !== 1'b0 ||
            release_pulse !== 1'b0 || long_press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: level=%b count=%0d pp=%b rp=%b lp=%b, required all 0",
                     btn_level, press_count, press_pulse, release_pulse, long_press_pulse);
        end
        reset = 1'b0;
        p0 = n_press; r0 = n_release; l0 = n_long;
        repeat (100) @(negedge clk);
        n_cmp++;
        if ((n_press - p0) != 0 || (n_release - r0) != 0 || (n_long - l0) != 0) begin
            n_fail++;
            $display("FAIL idle_no_pulse: press=%0d release=%0d long=%0d, required 0/0/0",
                     n_press - p0, n_release - r0, n_long - l0);
        end
        n_cmp++;
        if (btn_level !== 1'b0 || press_count !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_state: level=%b count=%0d, required 0/0", btn_level, press_count);
        end
    endtask

    task automatic test_clean_press;
        int p0, lat;
        bit found;
        p0 = n_press;
        found = 1'b0;
        lat = 0;
        @(negedge clk);
        btn_in = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (press_pulse) begin
                found = 1'b1;
                lat   = i;
            end
        end
        n_cmp++;
        if (!found || lat < 2 || lat > 15) begin
            n_fail++;
            $display("FAIL press_latency: found=%0d latency=%0d, required within 2..15", found, lat);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ((n_press - p0) != 1 || btn_level !== 1'b1 || press_count !== 4'd1) begin
            n_fail++;
            $display("FAIL clean_press: pulses=%0d level=%b count=%0d, required 1/1/1",
                     n_press - p0, btn_level, press_count);
        end
    endtask

    task automatic test_bounce;
        int p0, r0;
        do_reset(1'b1);
        p0 = n_press; r0 = n_release;
        for (int seg = 0; seg < 12; seg++) begin
            btn_in = seg[0];
            repeat (5) @(negedge clk);
        end
        n_cmp++;
        if ((n_press - p0) != 0 || (n_release - r0) != 0 || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_quiet: press=%0d release=%0d level=%b, required 0/0/0",
                     n_press - p0, n_release - r0, btn_level);
        end
        btn_in = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ((n_press - p0) != 1 || btn_level !== 1'b1 || press_count !== 4'd1) begin
            n_fail++;
            $display("FAIL bounce_settle: pulses=%0d level=%b count=%0d, required 1/1/1",
                     n_press - p0, btn_level, press_count);
        end
    endtask

    task automatic test_long_press;
        int l0, r0, k;
        bit found;
        @(negedge clk);
        btn_in = 1'b1;
        repeat (30) @(negedge clk);
        l0 = n_long; r0 = n_release;
        btn_in = 1'b0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (press_pulse) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL long_press_accept: no press_pulse within 20 cycles, required one");
        end
        found = 1'b0;
        k = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge clk);
            if (long_press_pulse) begin
                found = 1'b1;
                k     = i;
            end
        end
        n_cmp++;
        if (!found || k != 32) begin
            n_fail++;
            $display("FAIL long_press_timing: found=%0d cycles=%0d, required 32", found, k);
        end
        repeat (100) @(negedge clk);
        // One-tick release glitch while held.
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        btn_in = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if ((n_long - l0) != 1 || (n_release - r0) != 0 || btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL long_hold_glitch: long=%0d release=%0d level=%b, required 1/0/1",
                     n_long - l0, n_release - r0, btn_level);
        end
        btn_in = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if ((n_long - l0) != 1 || (n_release - r0) != 1 || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL long_release: long=%0d release=%0d level=%b, required 1/1/0",
                     n_long - l0, n_release - r0, btn_level);
        end
    endtask

    task automatic test_reset_mid_press;
        int r0, p0, lat;
        bit found;
        @(negedge clk);
        btn_in = 1'b0;
        repeat (30) @(negedge clk);
        r0 = n_release;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p0 = n_press;
        n_cmp++;
        if (btn_level !== 1'b0 || press_count !== 4'd0 || release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_press: level=%b count=%0d rp=%b, required 0/0/0",
                     btn_level, press_count, release_pulse);
        end
        found = 1'b0;
        lat = 0;
        for (int i = 1; i <= 15 && !found; i++) begin
            @(negedge clk);
            if (press_pulse) begin
                found = 1'b1;
                lat   = i;
            end
        end
        n_cmp++;
        if (!found || lat != 12) begin
            n_fail++;
            $display("FAIL redetect_latency: found=%0d latency=%0d, required 12", found, lat);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ((n_press - p0) != 1 || (n_release - r0) != 0 || press_count !== 4'd1) begin
            n_fail++;
            $display("FAIL redetect_count: press=%0d release=%0d count=%0d, required 1/0/1",
                     n_press - p0, n_release - r0, press_count);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        logic [3:0] exp_cnt;
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            p0 = n_press;
            exp_cnt = 4'(i + 1);
            btn_in = 1'b0;
            repeat (20) @(negedge clk);
            n_cmp++;
            if (press_count !== exp_cnt || (n_press - p0) != 1) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: count=%0d pulses=%0d, required %0d/1",
                         i, press_count, n_press - p0, exp_cnt);
            end
            btn_in = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        n_press   = 0;
        n_release = 0;
        n_long    = 0;
        reset     = 1'b1;
        btn_in    = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_reset_mid_press();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
